// File: rtl/uart_matrix_loader_pkg.sv
// rtl/uart_matrix_loader_pkg.sv - shared types and helpers for the UART matrix loader
package uart_matrix_loader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_MAT = 2'd1,
        LOAD_VEC = 2'd2,
        DONE     = 2'd3
    } loader_state_t;

    typedef struct packed {
        logic busy;
        logic load_done;
        logic size_err;
    } loader_status_t;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_matrix_loader_if.sv
// rtl/uart_matrix_loader_if.sv - control, rx byte stream and FIFO push bundle of the loader
interface uart_matrix_loader_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  n_size;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [NUM_CH-1:0] row_push;
    logic              vec_push;
    logic [DATA_W-1:0] push_data;
    logic              busy;
    logic              load_done;
    logic              size_err;

    modport slave (
        input  start, abort, n_size, rx_valid, rx_data,
        output row_push, vec_push, push_data, busy, load_done, size_err
    );

    modport master (
        output start, abort, n_size, rx_valid, rx_data,
        input  row_push, vec_push, push_data, busy, load_done, size_err
    );
endinterface

// File: rtl/uart_matrix_loader_wrap_counter.sv
// rtl/uart_matrix_loader_wrap_counter.sv - up counter that wraps to 0 after reaching limit
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_value,
    output logic         o_wrap
);
    logic [W-1:0] r_value;
    logic         w_at_limit;

    assign w_at_limit = (r_value == i_limit);
    assign o_wrap     = i_en && !i_clr && w_at_limit;
    assign o_value    = r_value;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= w_at_limit ? '0 : r_value + W'(1);
        end
    end
endmodule

// File: rtl/uart_matrix_loader.sv
// rtl/uart_matrix_loader.sv - splits a received N x N matrix plus N-vector into row/vector FIFO pushes
module uart_matrix_loader
    import uart_matrix_loader_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int MAX_N  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    uart_matrix_loader_if.slave   bus
);
    localparam int CNT_W = ceil_log2(MAX_N) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? ceil_log2(NUM_CH) : 1;

    loader_state_t     r_state;
    loader_state_t     w_next;
    loader_status_t    r_status;
    logic [CNT_W-1:0]  r_n;
    logic [NUM_CH-1:0] r_row_push;
    logic              r_vec_push;
    logic [DATA_W-1:0] r_push_data;

    logic [CNT_W-1:0]  w_limit;
    logic [CNT_W-1:0]  w_col;
    logic [CNT_W-1:0]  w_row;
    logic [CH_W-1:0]   w_ch;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_size_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_mat_acc;
    logic              w_vec_acc;
    logic              w_cnt_clr;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic              w_ch_wrap;

    assign w_limit     = r_n - CNT_W'(1);
    assign w_size_ok   = (bus.n_size != '0) && (bus.n_size <= CNT_W'(MAX_N));
    assign w_start_ok  = (r_state == IDLE) && !bus.abort && bus.start && w_size_ok;
    assign w_start_bad = (r_state == IDLE) && !bus.abort && bus.start && !w_size_ok;
    assign w_mat_acc   = (r_state == LOAD_MAT) && bus.rx_valid && !bus.abort;
    assign w_vec_acc   = (r_state == LOAD_VEC) && bus.rx_valid && !bus.abort;
    // Counters sit at zero whenever no load is in progress, so a new start always begins at row 0 col 0.
    assign w_cnt_clr   = bus.abort || !((r_state == LOAD_MAT) || (r_state == LOAD_VEC));
    assign w_onehot    = NUM_CH'(1) << w_ch;

    // The column counter doubles as the vector index: it is back at 0 when the matrix completes.
    wrap_counter #(.W(CNT_W)) u_col (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_mat_acc || w_vec_acc),
        .i_clr   (w_cnt_clr),
        .i_limit (w_limit),
        .o_value (w_col),
        .o_wrap  (w_col_wrap)
    );

    wrap_counter #(.W(CNT_W)) u_row (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_mat_acc && w_col_wrap),
        .i_clr   (w_cnt_clr),
        .i_limit (w_limit),
        .o_value (w_row),
        .o_wrap  (w_row_wrap)
    );

    wrap_counter #(.W(CH_W)) u_ch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_mat_acc && w_col_wrap),
        .i_clr   (w_cnt_clr),
        .i_limit (CH_W'(NUM_CH - 1)),
        .o_value (w_ch),
        .o_wrap  (w_ch_wrap)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_start_ok) w_next = LOAD_MAT;
            LOAD_MAT: begin
                if (bus.abort)       w_next = IDLE;
                else if (w_row_wrap) w_next = LOAD_VEC;
            end
            LOAD_VEC: begin
                if (bus.abort)                    w_next = IDLE;
                else if (w_vec_acc && w_col_wrap) w_next = DONE;
            end
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_status    <= '0;
            r_n         <= '0;
            r_row_push  <= '0;
            r_vec_push  <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_state            <= w_next;
            r_row_push         <= w_mat_acc ? w_onehot : '0;
            r_vec_push         <= w_vec_acc;
            r_status.busy      <= (w_next == LOAD_MAT) || (w_next == LOAD_VEC);
            r_status.load_done <= (r_state == DONE) && !bus.abort;
            if (w_mat_acc || w_vec_acc) begin
                r_push_data <= bus.rx_data;
            end
            if (w_start_ok) begin
                r_n               <= bus.n_size;
                r_status.size_err <= 1'b0;
            end else if (w_start_bad) begin
                r_status.size_err <= 1'b1;
            end
        end
    end

    assign bus.row_push  = r_row_push;
    assign bus.vec_push  = r_vec_push;
    assign bus.push_data = r_push_data;
    assign bus.busy      = r_status.busy;
    assign bus.load_done = r_status.load_done;
    assign bus.size_err  = r_status.size_err;
endmodule
